wordle_guess_scorer: RTL and testbench
======================================

Name: wordle_guess_scorer

Overview:
- Multi-cycle scorer that sequences the letter-comparison datapath for one Wordle guess.
- Takes a latched 5-letter guess and the 5-letter answer. Produces per-letter colors (green/yellow/gray) with correct duplicate-letter handling, plus a win flag.
- Sits beside the game state machine: the game SM pulses Start after the 5th letter is entered, waits for q_Done, then uses colors/win to pick its next guess state and Acks.

Parameters:
- LW, 8, bits per letter (ASCII uppercase).
- NL, 5, letters per word. The design is fixed at 5; the parameter is for width math only.

Ports:
- Clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  begin scoring; sampled only in state QI.
- Ack  input  1  result consumed; sampled only in state QDONE.
- guess  input  40  guess letters; letter 0 (leftmost) = guess[39:32], letter 4 = guess[7:0].
- answer  input  40  answer letters, same packing as guess.
- q_I  output  1  one-hot state bit: idle.
- q_Green  output  1  one-hot state bit: green pass.
- q_Yellow  output  1  one-hot state bit: yellow pass.
- q_Done  output  1  one-hot state bit: result valid.
- colors  output  10  2 bits per letter, letter 0 = colors[9:8]. Encoding: 00 gray, 01 yellow, 10 green; 11 never driven.
- win  output  1  all five letters green; valid while q_Done.

Behaviour:
- State encoding:
  - state is a 4-bit one-hot register.
  - QI=1000, QGREEN=0100, QYELLOW=0010, QDONE=0001.
  - {q_I,q_Green,q_Yellow,q_Done} = state.
- Reset (synchronous): state=QI, colors=0, win=0, I=0, J=0, used_a=0, g/a latches=0.
- A reset asserted in any state, including mid-pass, aborts the job. The next edge applies all reset values and no partial result is retained.
- QI:
  - If Start is high, latch guess->g and answer->a. Clear colors, used_a, I and J. Go to QGREEN.
  - Otherwise hold. colors/win keep their last values (both are 0 after reset).
- QGREEN: one letter per cycle, I=0..4.
  - If g[I]==a[I], then colors[I]=10 and used_a[I]=1.
  - If I==4, go to QYELLOW with I=0 and J=0. Otherwise I++.
  - The green pass always takes exactly 5 cycles.
- QYELLOW: examines one (I,J) pair per cycle.
  - If colors[I]==10, skip position I: advance I and set J=0. No compare.
  - Else if !used_a[J] and g[I]==a[J]: colors[I]=01, used_a[J]=1, advance I, set J=0.
  - Else if J==4: position I stays gray; advance I, set J=0.
  - Else J++.
  - "Advance I" with I==4 means: go to QDONE and set win = (colors==10'b1010101010), evaluated using the colors value written this cycle.
  - used_a guarantees that each answer letter satisfies at most one green or yellow. Surplus duplicate guess letters therefore stay gray.
- QDONE:
  - colors and win are held stable.
  - If Ack is high, go to QI. colors/win remain held until the next Start is accepted.
- Start outside QI and Ack outside QDONE are ignored.
- Start and Ack high together: only the one that matches the current state has any effect.
- Start high in QI on consecutive cycles: only the first is accepted; the rest land in QGREEN and are ignored.
- Latency, counted from the edge that samples Start to the edge that enters QDONE:
  - minimum 10 cycles (all green);
  - maximum 30 cycles (no greens, each non-green letter scans all 5 J).
- guess/answer may change after the Start edge without affecting the result.
- Counters: I and J are 3 bits and never exceed 4. The I and J values in QDONE are don't-care.

Test Plan:
- Reset, then Start with guess="CRANE", answer="CRANE" -> q_Done rises exactly 10 edges after the Start edge; colors=10'b1010101010, win=1. Ack -> q_I next cycle.
- guess="EERIE", answer="THREE" -> colors=10'b0100100010 (Y,gray,G,gray,G), win=0. Checks duplicate handling: the second E is gray.
- guess="AAAAA", answer="ABCDE" -> colors=10'b1000000000, win=0.
- guess="BBBBB", answer="CRANE" -> colors=0, win=0; q_Done exactly 30 edges after the Start edge.
- Assert reset while q_Yellow is high -> next edge gives state=QI, colors=0, win=0. A new Start then scores correctly.
- Pulse Start while in QGREEN and Ack while in QYELLOW -> no effect on state or result. Hold Ack low in QDONE for 20 cycles -> colors/win stable throughout.

Source files
------------

// File: rtl/wordle_guess_scorer.sv
// -----------------------------------------------------------------------------
// wordle_guess_scorer
//
// Purpose:
//   Multi-cycle scorer for one Wordle guess. When Start is seen in idle, the
//   guess and answer words are latched. A green pass then walks the five
//   positions one per cycle. A yellow pass follows and scans the answer
//   letters for every position that is not green. Each answer letter can
//   justify at most one green or yellow, so surplus duplicate guess letters
//   stay gray. The result is held in QDONE until Ack is seen.
//
// Ports:
//   Clk      - system clock, all logic on posedge
//   reset    - synchronous, active-high reset
//   Start    - begin scoring (sampled only in QI)
//   Ack      - result consumed (sampled only in QDONE)
//   guess    - guess letters, letter 0 in the top byte
//   answer   - answer letters, same packing as guess
//   q_I      - one-hot state bit: idle
//   q_Green  - one-hot state bit: green pass
//   q_Yellow - one-hot state bit: yellow pass
//   q_Done   - one-hot state bit: result valid
//   colors   - 2 bits per letter, letter 0 in colors[9:8]
//              (00 gray, 01 yellow, 10 green)
//   win      - all five letters green, valid while q_Done
// -----------------------------------------------------------------------------
module wordle_guess_scorer #(
  parameter int LW = 8,
  parameter int NL = 5
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic [NL*LW-1:0] guess,
  input  logic [NL*LW-1:0] answer,
  output logic             q_I,
  output logic             q_Green,
  output logic             q_Yellow,
  output logic             q_Done,
  output logic [2*NL-1:0]  colors,
  output logic             win
);

  typedef enum logic [3:0] {
    QI      = 4'b1000,
    QGREEN  = 4'b0100,
    QYELLOW = 4'b0010,
    QDONE   = 4'b0001
  } state_t;

  localparam logic [1:0] GRAY   = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  state_t           state;
  logic [NL*LW-1:0] g;
  logic [NL*LW-1:0] a;
  logic [1:0]       col_q   [NL];
  logic [NL-1:0]    used_a;
  logic [2:0]       i;
  logic [2:0]       j;

  logic [LW-1:0]    g_l     [NL];
  logic [LW-1:0]    a_l     [NL];
  logic [1:0]       next_col [NL];
  logic             skip_pos;
  logic             yellow_hit;
  logic             advance_i;
  logic             all_green_next;

  // The state register is the one-hot encoding itself, so the status
  // outputs are simply its bits.
  assign {q_I, q_Green, q_Yellow, q_Done} = state;

  // Repack the per-letter color registers into the packed output bus,
  // with letter 0 in the most significant pair.
  always_comb begin
    colors = '0;
    for (int k = 0; k < NL; k++) begin
      colors[(NL-1-k)*2 +: 2] = col_q[k];
    end
  end

  // Split the latched words into letter arrays so that the datapath can
  // index letters with the I and J counters directly.
  always_comb begin
    for (int k = 0; k < NL; k++) begin
      g_l[k] = g[(NL-1-k)*LW +: LW];
      a_l[k] = a[(NL-1-k)*LW +: LW];
    end
  end

  // Decision for one yellow-pass step. A green position is skipped without
  // any compare. Otherwise an unused matching answer letter at J turns the
  // position yellow. Running out of J leaves the position gray. next_col is
  // the color set as it will look after this step. The win flag is taken
  // from next_col so that it reflects the value written on the final step.
  always_comb begin
    next_col   = col_q;
    skip_pos   = (col_q[i] == GREEN);
    yellow_hit = 1'b0;
    if (!skip_pos && !used_a[j] && (g_l[i] == a_l[j])) begin
      yellow_hit  = 1'b1;
      next_col[i] = YELLOW;
    end
    advance_i      = skip_pos || yellow_hit || (j == 3'd4);
    all_green_next = 1'b1;
    for (int k = 0; k < NL; k++) begin
      if (next_col[k] != GREEN) begin
        all_green_next = 1'b0;
      end
    end
  end

  // Main sequencer. A reset aborts any job in progress and clears every
  // piece of partial state. Start is only honoured in QI and Ack only in
  // QDONE, so stray pulses in the other states fall through harmlessly.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state  <= QI;
      g      <= '0;
      a      <= '0;
      used_a <= '0;
      i      <= 3'd0;
      j      <= 3'd0;
      win    <= 1'b0;
      for (int k = 0; k < NL; k++) begin
        col_q[k] <= GRAY;
      end
    end else begin
      case (state)
        QI: begin
          if (Start) begin
            g      <= guess;
            a      <= answer;
            used_a <= '0;
            i      <= 3'd0;
            j      <= 3'd0;
            win    <= 1'b0;
            for (int k = 0; k < NL; k++) begin
              col_q[k] <= GRAY;
            end
            state <= QGREEN;
          end
        end

        QGREEN: begin
          if (g_l[i] == a_l[i]) begin
            col_q[i]  <= GREEN;
            used_a[i] <= 1'b1;
          end
          if (i == 3'd4) begin
            i     <= 3'd0;
            j     <= 3'd0;
            state <= QYELLOW;
          end else begin
            i <= i + 3'd1;
          end
        end

        QYELLOW: begin
          if (yellow_hit) begin
            used_a[j] <= 1'b1;
          end
          col_q[i] <= next_col[i];
          if (advance_i) begin
            j <= 3'd0;
            if (i == 3'd4) begin
              win   <= all_green_next;
              state <= QDONE;
            end else begin
              i <= i + 3'd1;
            end
          end else begin
            j <= j + 3'd1;
          end
        end

        QDONE: begin
          if (Ack) begin
            state <= QI;
          end
        end

        default: begin
          state <= QI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// -----------------------------------------------------------------------------
// tb_wordle_guess_scorer
//
// Purpose:
//   Self-checking bench for wordle_guess_scorer. It runs directed words and
//   randomly drawn words from a small alphabet, which makes duplicate letters
//   common. Results are compared with a word-level Wordle scoring model that
//   also predicts the scoring latency.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_wordle_guess_scorer;

  logic        Clk;
  logic        reset;
  logic        Start;
  logic        Ack;
  logic [39:0] guess;
  logic [39:0] answer;
  logic        q_I;
  logic        q_Green;
  logic        q_Yellow;
  logic        q_Done;
  logic [9:0]  colors;
  logic        win;

  int checks;
  int failures;

  wordle_guess_scorer #(.LW(8), .NL(5)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .Start    (Start),
    .Ack      (Ack),
    .guess    (guess),
    .answer   (answer),
    .q_I      (q_I),
    .q_Green  (q_Green),
    .q_Yellow (q_Yellow),
    .q_Done   (q_Done),
    .colors   (colors),
    .win      (win)
  );

  // Free-running clock, 10 time units per period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Word-level Wordle scoring. Greens claim their answer letters first.
  // Each remaining guess letter, taken left to right, claims the leftmost
  // unclaimed equal answer letter. Latency is 5 cycles for the green pass
  // plus the cost of the scan for each position: 1 for a green, j+1 when
  // the match is found at answer index j, and 5 when no match is found.
  function automatic void scoreModel(input logic [39:0] gw, input logic [39:0] aw,
                                     output logic [9:0] col, output logic w,
                                     output int lat);
    logic [7:0] gl [5];
    logic [7:0] al [5];
    bit         used [5];
    bit         grn  [5];
    int         found;
    col = '0;
    lat = 5;
    for (int p = 0; p < 5; p++) begin
      gl[p]   = gw[39-8*p -: 8];
      al[p]   = aw[39-8*p -: 8];
      used[p] = (gl[p] == al[p]);
      grn[p]  = used[p];
    end
    for (int p = 0; p < 5; p++) begin
      if (grn[p]) begin
        col[9-2*p -: 2] = 2'b10;
        lat += 1;
      end else begin
        found = -1;
        for (int q = 0; q < 5; q++) begin
          if (found < 0 && !used[q] && gl[p] == al[q]) found = q;
        end
        if (found >= 0) begin
          used[found] = 1'b1;
          col[9-2*p -: 2] = 2'b01;
          lat += found + 1;
        end else begin
          lat += 5;
        end
      end
    end
    w = (col == 10'b1010101010);
  endfunction

  // Runs one scoring job: pulses Start, changes the inputs right after the
  // Start edge, and waits (bounded) for q_Done. It then checks latency and
  // results, optionally holds the result for a while, and finally Acks.
  // With inject set, a stray Start is pulsed during the green pass and a
  // stray Ack during the yellow pass.
  task automatic applyStimulus(input string tag, input logic [39:0] gw,
                               input logic [39:0] aw, input bit inject,
                               input bit holdLong);
    logic [9:0] expCol;
    logic       expWin;
    int         expLat;
    int         edges;
    bit         sentS;
    bit         sentA;
    scoreModel(gw, aw, expCol, expWin, expLat);
    @(negedge Clk);
    guess  = gw;
    answer = aw;
    Start  = 1'b1;
    @(negedge Clk);
    Start  = 1'b0;
    guess  = $urandom;
    answer = $urandom;
    checkOutput({tag, "_q_green"}, {28'd0, q_I, q_Green, q_Yellow, q_Done}, 32'h4);
    edges = 0;
    sentS = 1'b0;
    sentA = 1'b0;
    while (!q_Done && edges < 60) begin
      if (inject && q_Green && !sentS) begin
        Start = 1'b1;
        sentS = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (inject && q_Yellow && !sentA) begin
        Ack   = 1'b1;
        sentA = 1'b1;
      end else begin
        Ack = 1'b0;
      end
      @(negedge Clk);
      edges++;
    end
    Start = 1'b0;
    Ack   = 1'b0;
    checkOutput({tag, "_done"}, {31'd0, q_Done}, 32'd1);
    checkOutput({tag, "_latency"}, edges, expLat);
    checkOutput({tag, "_colors"}, {22'd0, colors}, {22'd0, expCol});
    checkOutput({tag, "_win"}, {31'd0, win}, {31'd0, expWin});
    if (holdLong) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge Clk);
        checkOutput({tag, "_hold_done"}, {31'd0, q_Done}, 32'd1);
        checkOutput({tag, "_hold_colors"}, {22'd0, colors}, {22'd0, expCol});
        checkOutput({tag, "_hold_win"}, {31'd0, win}, {31'd0, expWin});
      end
    end
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    checkOutput({tag, "_ack_idle"}, {28'd0, q_I, q_Green, q_Yellow, q_Done}, 32'h8);
    checkOutput({tag, "_ack_colors"}, {22'd0, colors}, {22'd0, expCol});
  endtask

  logic [39:0] rg;
  logic [39:0] ra;
  int          waitCnt;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Start    = 1'b0;
    Ack      = 1'b0;
    guess    = '0;
    answer   = '0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_state", {28'd0, q_I, q_Green, q_Yellow, q_Done}, 32'h8);
    checkOutput("reset_colors", {22'd0, colors}, 32'd0);
    checkOutput("reset_win", {31'd0, win}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("idle_hold", {28'd0, q_I, q_Green, q_Yellow, q_Done}, 32'h8);

    applyStimulus("crane", "CRANE", "CRANE", 1'b0, 1'b0);
    applyStimulus("eerie", "EERIE", "THREE", 1'b0, 1'b0);
    checkOutput("eerie_literal", {22'd0, colors}, {22'd0, 10'b0100100010});
    applyStimulus("aaaaa", "AAAAA", "ABCDE", 1'b0, 1'b0);
    checkOutput("aaaaa_literal", {22'd0, colors}, {22'd0, 10'b1000000000});
    applyStimulus("bbbbb", "BBBBB", "CRANE", 1'b0, 1'b0);

    // Abort a job partway through the yellow pass.
    @(negedge Clk);
    guess  = "CRABS";
    answer = "CRANE";
    Start  = 1'b1;
    @(negedge Clk);
    Start   = 1'b0;
    waitCnt = 0;
    while (!q_Yellow && waitCnt < 20) begin
      @(negedge Clk);
      waitCnt++;
    end
    checkOutput("abort_reached_yellow", {31'd0, q_Yellow}, 32'd1);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    checkOutput("abort_state", {28'd0, q_I, q_Green, q_Yellow, q_Done}, 32'h8);
    checkOutput("abort_colors", {22'd0, colors}, 32'd0);
    checkOutput("abort_win", {31'd0, win}, 32'd0);
    applyStimulus("after_abort", "CRABS", "CRANE", 1'b0, 1'b0);

    // Stray Start/Ack pulses, plus a long hold of the result in QDONE.
    applyStimulus("inject", "SPEED", "ERASE", 1'b1, 1'b1);
    applyStimulus("inject_win", "PLANT", "PLANT", 1'b1, 1'b0);

    // Random words from a four-letter alphabet to stress duplicates.
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 5; p++) begin
        rg[39-8*p -: 8] = 8'(8'd65 + 8'($urandom_range(0, 3)));
        ra[39-8*p -: 8] = 8'(8'd65 + 8'($urandom_range(0, 3)));
      end
      if (n % 10 == 0) ra = rg;
      applyStimulus("rand", rg, ra, (n % 3) == 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
